// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the hazard controller (register select, sequencer state).
package cpu_types_pkg;
  localparam int REG_BITS = 5;
  typedef logic [REG_BITS-1:0] regbits_t;
  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} hazctl_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and DE sources.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] de_rsel1,
  input  logic [REG_W-1:0] de_rsel2,
  input  logic             de_uses_rs2,
  output logic             load_use
);
  assign load_use = ex_mem_read && ex_wsel != '0 &&
                    (ex_wsel == de_rsel1 || (de_uses_rs2 && ex_wsel == de_rsel2));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/enable sequencer for the FD/DE/EM/MW registers and PC.
// PIPE_PERF_CNT_EN adds stall/flush performance counters; otherwise they read zero.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_access,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic [REG_W-1:0]  de_rsel1,
  input  logic [REG_W-1:0]  de_rsel2,
  input  logic              de_uses_rs2,
  input  logic              ex_redirect,
  input  logic              mem_halt,
  output logic              pc_en,
  output logic              fd_stall,
  output logic              fd_flush,
  output logic              de_stall,
  output logic              de_flush,
  output logic              em_en,
  output logic              mw_en,
  output logic              halt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end
  hazctl_state_t state, state_n;
  logic pend, pend_n, load_use, redir, unused_ihit;
  logic [DW-1:0] cnt, cnt_n;
  assign unused_ihit = ihit;
  assign halt = state == HALTED;
  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_mem_read(ex_mem_read),
    .ex_wsel(ex_wsel),
    .de_rsel1(de_rsel1),
    .de_rsel2(de_rsel2),
    .de_uses_rs2(de_uses_rs2),
    .load_use(load_use)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= RUN;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n  = state;
    pend_n   = pend;
    cnt_n    = cnt;
    redir    = 1'b0;
    pc_en    = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_stall = 1'b0;
    de_flush = 1'b0;
    em_en    = 1'b0;
    mw_en    = 1'b0;
    case (state)
      RUN, MEMWAIT:
        if (state == MEMWAIT ? !dhit : (mem_access && !dhit)) begin
          fd_stall = 1'b1;
          state_n  = MEMWAIT;
          pend_n   = pend | ex_redirect;
        end else begin
          // a redirect held over the miss is applied on the cycle the access completes
          redir    = pend | ex_redirect;
          pc_en    = redir | !load_use;
          fd_stall = !redir & load_use;
          de_stall = !redir & load_use;
          fd_flush = redir;
          de_flush = redir;
          em_en    = 1'b1;
          mw_en    = 1'b1;
          pend_n   = 1'b0;
          state_n  = mem_halt ? DRAIN : RUN;
          cnt_n    = mem_halt ? DW'(DRAIN_CYCLES - 1) : cnt;
        end
      DRAIN: begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
        em_en    = 1'b1;
        mw_en    = 1'b1;
        state_n  = cnt == '0 ? HALTED : DRAIN;
        cnt_n    = cnt == '0 ? cnt : cnt - 1'b1;
      end
      HALTED: state_n = HALTED;
    endcase
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALTED && !pc_en) stall_cnt <= stall_cnt + 1'b1;
      if (redir) flush_cnt <= flush_cnt + 1'b1;
    end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed literal checks plus randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN_CYCLES = 2;
  logic CLK = 1'b0, nRST;
  logic ihit, dhit, mem_access, ex_mem_read, de_uses_rs2, ex_redirect, mem_halt;
  logic [4:0] ex_wsel, de_rsel1, de_rsel2;
  logic pc_en, fd_stall, fd_flush, de_stall, de_flush, em_en, mw_en, halt;
  logic [31:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;
  bit run = 0;
  pipeline_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(DRAIN_CYCLES), .PERF_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_access(mem_access),
    .ex_mem_read(ex_mem_read), .ex_wsel(ex_wsel), .de_rsel1(de_rsel1), .de_rsel2(de_rsel2),
    .de_uses_rs2(de_uses_rs2), .ex_redirect(ex_redirect), .mem_halt(mem_halt),
    .pc_en(pc_en), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall),
    .de_flush(de_flush), .em_en(em_en), .mw_en(mw_en), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 CLK = ~CLK;
  wire [7:0] act = {pc_en, fd_stall, fd_flush, de_stall, de_flush, em_en, mw_en, halt};
  // model: miss-wait flag, held redirect, remaining drain cycles (-1 = not draining), halted
  bit m_wait, m_pend, m_halt, lu, r, frz;
  int m_drain = -1;
  logic [31:0] m_stall, m_flush, x_stall, x_flush;
  logic [7:0] e;
  always @(negedge CLK) if (run) begin
    if (!nRST) begin
      m_wait = 0; m_pend = 0; m_halt = 0; m_drain = -1; m_stall = 0; m_flush = 0;
    end
    lu = ex_mem_read && ex_wsel != 0 &&
         (ex_wsel == de_rsel1 || (de_uses_rs2 && ex_wsel == de_rsel2));
    frz = m_wait ? !dhit : (mem_access && !dhit);
    r = 0;
    if (m_halt) e = 8'b0000_0001;
    else if (m_drain >= 0) e = 8'b0010_1110;
    else if (frz) e = 8'b0100_0000;
    else begin
      r = m_pend || ex_redirect;
      e = {r || !lu, !r && lu, r, !r && lu, r, 1'b1, 1'b1, 1'b0};
    end
`ifdef PIPE_PERF_CNT_EN
    x_stall = m_stall; x_flush = m_flush;
`else
    x_stall = 0; x_flush = 0;
`endif
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL outs t=%0t got=%b exp=%b (pc,fs,ff,ds,df,em,mw,h)", $time, act, e);
    end
    checks++;
    if (stall_cnt !== x_stall) begin
      failures++;
      $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, x_stall);
    end
    checks++;
    if (flush_cnt !== x_flush) begin
      failures++;
      $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, x_flush);
    end
    if (nRST) begin
      if (!m_halt && !e[7]) m_stall++;
      if (r) m_flush++;
      if (m_halt) ;
      else if (m_drain >= 0) begin
        if (m_drain == 0) begin m_halt = 1; m_drain = -1; end
        else m_drain--;
      end else if (frz) begin
        m_wait = 1; m_pend = m_pend || ex_redirect;
      end else begin
        m_wait = 0; m_pend = 0;
        if (mem_halt) m_drain = DRAIN_CYCLES - 1;
      end
    end
  end
  task automatic idle;
    ihit = 1; dhit = 0; mem_access = 0; ex_mem_read = 0; ex_wsel = 0; de_rsel1 = 0;
    de_rsel2 = 0; de_uses_rs2 = 0; ex_redirect = 0; mem_halt = 0;
  endtask
  task automatic next;
    @(posedge CLK); #1;
  endtask
  task automatic lit(input string name, input logic [7:0] exp);
    #1;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask
  task automatic rnd;
    ihit = 1'($urandom); dhit = 1'($urandom); mem_access = $urandom_range(9, 0) < 3;
    ex_mem_read = 1'($urandom); ex_wsel = 5'($urandom_range(3, 0));
    de_rsel1 = 5'($urandom_range(3, 0)); de_rsel2 = 5'($urandom_range(3, 0));
    de_uses_rs2 = 1'($urandom); ex_redirect = $urandom_range(3, 0) == 0;
    mem_halt = $urandom_range(63, 0) == 0;
  endtask
  initial begin
    nRST = 0; idle();
    run = 1;
    #1 lit("reset", 8'b1000_0110);
    next(); next(); nRST = 1;
    ex_mem_read = 1; ex_wsel = 5; de_rsel1 = 5;
    lit("load_use", 8'b0101_0110);
    next(); idle(); lit("after_bubble", 8'b1000_0110);
    ex_mem_read = 1; ex_wsel = 0; de_rsel1 = 0; lit("x0_no_stall", 8'b1000_0110);
    next(); idle(); mem_access = 1; ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      lit("miss_freeze", 8'b0100_0000);
      next();
    end
    dhit = 1; ex_redirect = 0; lit("miss_done_flush", 8'b1010_1110);
    next(); idle(); lit("after_miss", 8'b1000_0110);
    ex_redirect = 1; ex_mem_read = 1; ex_wsel = 7; de_rsel2 = 7; de_uses_rs2 = 1;
    lit("redir_over_lu", 8'b1010_1110);
    next(); idle(); mem_halt = 1; lit("halt_enter", 8'b1000_0110);
    next(); idle(); ex_redirect = 1; lit("drain1", 8'b0010_1110);
    next(); lit("drain2", 8'b0010_1110);
    next(); lit("halted", 8'b0000_0001);
    next(); rnd(); lit("halt_sticky", 8'b0000_0001);
    nRST = 0; idle(); lit("halt_cleared", 8'b1000_0110);
    next(); nRST = 1;
    for (int i = 0; i < 4000; i++) begin
      next(); rnd();
      if ($urandom_range(499, 0) == 0 || (halt && $urandom_range(7, 0) == 0)) begin
        nRST = 0; next(); rnd(); nRST = 1;
      end
    end
    next(); run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
